// File: rtl/shift_sub_divider_pkg.sv
// Shared types and helpers for the shift/subtract divider.
package div_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'b001,
        LOAD  = 3'b010,
        SHIFT = 3'b011,
        SUB   = 3'b100,
        DONE  = 3'b101,
        FIX   = 3'b110
    } div_state_t;

    // Counter must reach 'size' without wrapping, hence one bit beyond $clog2.
    function automatic int unsigned cnt_width(input int unsigned size);
        return $clog2(size) + 1;
    endfunction

endpackage

// File: rtl/shift_sub_divider_if.sv
// Operand/result bundle for the divider; master drives the request, slave returns results.
interface shift_sub_divider_if #(
    parameter int unsigned size = 8
);
    logic            START;
    logic [size-1:0] dividend;
    logic [size-1:0] divisor;
    logic [size-1:0] quotient;
    logic [size-1:0] remainder;
    logic            END_DIV;
    logic            DIV_BY_ZERO;

    modport master (
        output START, dividend, divisor,
        input  quotient, remainder, END_DIV, DIV_BY_ZERO
    );

    modport slave (
        input  START, dividend, divisor,
        output quotient, remainder, END_DIV, DIV_BY_ZERO
    );
endinterface

// File: rtl/div_iter_counter.sv
// Iteration counter for the divider: synchronous clear has priority over enable.
module div_iter_counter #(
    parameter int unsigned width = 4
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             clear,
    input  logic             en,
    output logic [width-1:0] count
);

    always_ff @(posedge CLOCK) begin
        if (RESET || clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + width'(1);
        end
    end

endmodule

// File: rtl/shift_sub_divider.sv
// Restoring divider, one quotient bit per SHIFT/SUB pair, level START/END_DIV handshake.
// Define SIGNED_DIV_EN for two's-complement operands (adds a FIX cycle before DONE).
module shift_sub_divider
    import div_pkg::*;
#(
    parameter int unsigned size = 8
) (
    input logic                CLOCK,
    input logic                RESET,
    shift_sub_divider_if.slave bus
);

    localparam int unsigned CntW = cnt_width(size);

    div_state_t      state_q, state_d;
    logic [size-1:0] q_q, q_d;
    logic [size-1:0] m_q, m_d;
    logic [size:0]   r_q, r_d;
    logic [size-1:0] quot_q, quot_d;
    logic [size-1:0] rem_q, rem_d;
    logic            dbz_q, dbz_d;
    logic [size:0]   t;
    logic            cnt_clear;
    logic            cnt_en;
    logic [CntW-1:0] cnt;

`ifdef SIGNED_DIV_EN
    logic neg_q_q, neg_q_d;
    logic neg_r_q, neg_r_d;

    function automatic logic [size-1:0] neg(input logic [size-1:0] v);
        return ~v + size'(1);
    endfunction
`endif

    div_iter_counter #(
        .width(CntW)
    ) u_cnt (
        .CLOCK(CLOCK),
        .RESET(RESET),
        .clear(cnt_clear),
        .en   (cnt_en),
        .count(cnt)
    );

    assign t = r_q - {1'b0, m_q};

    always_comb begin
        state_d   = state_q;
        q_d       = q_q;
        m_d       = m_q;
        r_d       = r_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        dbz_d     = dbz_q;
        cnt_clear = 1'b0;
        cnt_en    = 1'b0;
`ifdef SIGNED_DIV_EN
        neg_q_d   = neg_q_q;
        neg_r_d   = neg_r_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.START) begin
                    state_d = LOAD;
                end
            end

            LOAD: begin
`ifdef SIGNED_DIV_EN
                // Iterate on magnitudes; -2^(size-1) stays as its unsigned bit pattern.
                q_d     = bus.dividend[size-1] ? neg(bus.dividend) : bus.dividend;
                m_d     = bus.divisor[size-1] ? neg(bus.divisor) : bus.divisor;
                neg_q_d = bus.dividend[size-1] ^ bus.divisor[size-1];
                neg_r_d = bus.dividend[size-1];
`else
                q_d     = bus.dividend;
                m_d     = bus.divisor;
`endif
                r_d       = '0;
                cnt_clear = 1'b1;
                if (bus.divisor == '0) begin
                    quot_d  = '1;
                    rem_d   = bus.dividend;
                    dbz_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    dbz_d   = 1'b0;
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                {r_d, q_d} = {r_q[size-1:0], q_q, 1'b0};
                cnt_en     = 1'b1;
                state_d    = SUB;
            end

            SUB: begin
                // Negative trial difference means restore: R keeps its value.
                if (!t[size]) begin
                    r_d = t;
                end
                q_d = {q_q[size-1:1], ~t[size]};
                if (cnt == CntW'(size)) begin
`ifdef SIGNED_DIV_EN
                    state_d = FIX;
`else
                    quot_d  = q_d;
                    rem_d   = r_d[size-1:0];
                    state_d = DONE;
`endif
                end else begin
                    state_d = SHIFT;
                end
            end

`ifdef SIGNED_DIV_EN
            FIX: begin
                // Remainder takes the dividend's sign so the quotient truncates toward zero.
                quot_d  = neg_q_q ? neg(q_q) : q_q;
                rem_d   = neg_r_q ? neg(r_q[size-1:0]) : r_q[size-1:0];
                state_d = DONE;
            end
`endif

            DONE: begin
                if (!bus.START) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q <= IDLE;
            q_q     <= '0;
            m_q     <= '0;
            r_q     <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
`ifdef SIGNED_DIV_EN
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            m_q     <= m_d;
            r_q     <= r_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
`ifdef SIGNED_DIV_EN
            neg_q_q <= neg_q_d;
            neg_r_q <= neg_r_d;
`endif
        end
    end

    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.DIV_BY_ZERO = dbz_q;
    assign bus.END_DIV     = (state_q == DONE);

endmodule

// File: tb/tb_shift_sub_divider.sv
// Directed, table-driven bench for shift_sub_divider (unsigned or SIGNED_DIV_EN build).
module tb_shift_sub_divider;

    logic CLOCK = 1'b0;
    logic RESET;

    always #5 CLOCK = ~CLOCK;

    shift_sub_divider_if #(.size(8)) bus ();

    shift_sub_divider #(
        .size(8)
    ) dut (
        .CLOCK(CLOCK),
        .RESET(RESET),
        .bus  (bus)
    );

`ifdef SIGNED_DIV_EN
    localparam int LatOp = 18;
    localparam logic [7:0] Q200by9 = 8'hFA;  // -56 / 9
    localparam logic [7:0] R200by9 = 8'hFE;
`else
    localparam int LatOp = 17;
    localparam logic [7:0] Q200by9 = 8'd22;
    localparam logic [7:0] R200by9 = 8'd2;
`endif

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       z;
        int         lat;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Raises START and waits for END_DIV, scrambling the operands once LOAD is past.
    task automatic run_op(input string nm, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] eq, input logic [7:0] er, input logic ez,
                          input int elat);
        int n;
        bit seen;
        n    = 0;
        seen = 0;
        @(negedge CLOCK);
        bus.dividend = a;
        bus.divisor  = b;
        bus.START    = 1'b1;
        @(posedge CLOCK);
        while (!seen && n < 40) begin
            @(posedge CLOCK);
            n++;
            #1;
            seen = bus.END_DIV;
            if (n == 1) begin
                bus.dividend = ~a;
                bus.divisor  = b ^ 8'h5A;
            end
        end
        check({nm, " latency"}, n, elat);
        check({nm, " quotient"}, bus.quotient, eq);
        check({nm, " remainder"}, bus.remainder, er);
        check({nm, " div_by_zero"}, bus.DIV_BY_ZERO, ez);
    endtask

    task automatic finish_op(input string nm, input logic [7:0] eq);
        @(negedge CLOCK);
        bus.START = 1'b0;
        @(posedge CLOCK);
        #1;
        check({nm, " end_div drop"}, bus.END_DIV, 1'b0);
        check({nm, " quotient kept"}, bus.quotient, eq);
    endtask

    initial begin
        int n;
        bit seen;

`ifdef SIGNED_DIV_EN
        vecs.push_back('{8'd100, 8'd7,  8'h0E, 8'h02, 1'b0, LatOp});
        vecs.push_back('{8'hF9,  8'h02, 8'hFD, 8'hFF, 1'b0, LatOp});
        vecs.push_back('{8'h07,  8'hFE, 8'hFD, 8'h01, 1'b0, LatOp});
        vecs.push_back('{8'h05,  8'h00, 8'hFF, 8'h05, 1'b1, 1});
        vecs.push_back('{8'h80,  8'hFF, 8'h80, 8'h00, 1'b0, LatOp});
        vecs.push_back('{8'h9C,  8'hF9, 8'h0E, 8'hFE, 1'b0, LatOp});
        vecs.push_back('{8'hF9,  8'h00, 8'hFF, 8'hF9, 1'b1, 1});
        vecs.push_back('{8'd3,   8'd100, 8'h00, 8'h03, 1'b0, LatOp});
`else
        vecs.push_back('{8'd100, 8'd7,   8'd14,  8'd2, 1'b0, LatOp});
        vecs.push_back('{8'd5,   8'd0,   8'hFF,  8'd5, 1'b1, 1});
        vecs.push_back('{8'd255, 8'd1,   8'd255, 8'd0, 1'b0, LatOp});
        vecs.push_back('{8'd3,   8'd200, 8'd0,   8'd3, 1'b0, LatOp});
        vecs.push_back('{8'd255, 8'd255, 8'd1,   8'd0, 1'b0, LatOp});
        vecs.push_back('{8'd0,   8'd5,   8'd0,   8'd0, 1'b0, LatOp});
        vecs.push_back('{8'd128, 8'd16,  8'd8,   8'd0, 1'b0, LatOp});
        vecs.push_back('{8'd250, 8'd3,   8'd83,  8'd1, 1'b0, LatOp});
`endif

        RESET        = 1'b1;
        bus.START    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (2) @(posedge CLOCK);
        #1;
        check("reset end_div", bus.END_DIV, 1'b0);
        check("reset quotient", bus.quotient, 8'h00);
        check("reset remainder", bus.remainder, 8'h00);
        check("reset div_by_zero", bus.DIV_BY_ZERO, 1'b0);
        @(negedge CLOCK);
        RESET = 1'b0;

        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r,
                   vecs[i].z, vecs[i].lat);
            finish_op($sformatf("vec%0d", i), vecs[i].q);
        end

        // START held in DONE: result must stay put.
        run_op("hold", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, LatOp);
        for (int k = 0; k < 10; k++) begin
            @(posedge CLOCK);
            #1;
            check("hold end_div", bus.END_DIV, 1'b1);
            check("hold quotient", bus.quotient, 8'd14);
        end
        finish_op("hold", 8'd14);

        // Reset in the middle of 200/9.
        @(negedge CLOCK);
        bus.dividend = 8'd200;
        bus.divisor  = 8'd9;
        bus.START    = 1'b1;
        @(posedge CLOCK);
        repeat (5) @(posedge CLOCK);
        @(negedge CLOCK);
        RESET     = 1'b1;
        bus.START = 1'b0;
        @(posedge CLOCK);
        #1;
        check("midreset end_div", bus.END_DIV, 1'b0);
        check("midreset quotient", bus.quotient, 8'h00);
        check("midreset remainder", bus.remainder, 8'h00);
        check("midreset div_by_zero", bus.DIV_BY_ZERO, 1'b0);
        @(negedge CLOCK);
        RESET = 1'b0;
        @(posedge CLOCK);
        #1;
        check("midreset idle", bus.END_DIV, 1'b0);
        run_op("after_reset", 8'd200, 8'd9, Q200by9, R200by9, 1'b0, LatOp);
        finish_op("after_reset", Q200by9);

        // START dropped early: operation completes, DONE lasts one cycle.
        @(negedge CLOCK);
        bus.dividend = 8'd100;
        bus.divisor  = 8'd7;
        bus.START    = 1'b1;
        @(posedge CLOCK);
        repeat (3) @(posedge CLOCK);
        @(negedge CLOCK);
        bus.START = 1'b0;
        n    = 3;
        seen = 0;
        while (!seen && n < 40) begin
            @(posedge CLOCK);
            n++;
            #1;
            seen = bus.END_DIV;
        end
        check("early latency", n, LatOp);
        check("early quotient", bus.quotient, 8'd14);
        check("early remainder", bus.remainder, 8'd2);
        @(posedge CLOCK);
        #1;
        check("early exit", bus.END_DIV, 1'b0);
        repeat (3) @(posedge CLOCK);
        #1;
        check("early no restart", bus.END_DIV, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
